dmem_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory (dmem) between the MIPS core's load/store port and an external requester (debug/loader).
- Sits between `mips` and `dmem` inside `top`.
- Captures one request at a time, drives the memory bus for exactly one cycle, then returns an ack with the read data.
- The core uses `cpu_stall` to freeze its PC while a load/store is outstanding.

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port 8-bit data memory
//
// Purpose:
//   Shares dmem between the MIPS core load/store port and an external
//   (debug/loader) requester. One request is captured at a time; the memory
//   bus is driven from latched copies for exactly one cycle (ACCESS), and the
//   winner receives a one-cycle ack with the read data in the cycle after
//   (RESP). Contention is resolved round-robin or with fixed CPU priority.
//
// Ports:
//   clk                     system clock, all state changes on rising edge
//   reset                   asynchronous active-low reset
//   cpu_req/we/addr/wdata   core request, held until cpu_ack
//   cpu_ack, cpu_rdata      one-cycle completion pulse and load data
//   cpu_stall               cpu_req & ~cpu_ack, freezes the core PC
//   ext_req/we/addr/wdata   external request, held until ext_ack
//   ext_ack, ext_rdata      one-cycle completion pulse and load data
//   mem_addr/we/wdata       dmem bus, driven from latched request copies
//   mem_rdata               dmem combinational read data of mem_addr
//   busy                    high whenever a request is in flight

module dmem_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_EXT = 1'b1;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          grant_ext;

    // Winner selection. Under contention with round-robin, whoever was not
    // served last wins; last_q resets to EXT so the CPU wins first.
    always_comb begin
        grant_ext = ext_req;
        if (cpu_req && ext_req) begin
            if (ROUND_ROBIN != 0) begin
                grant_ext = (last_q == SEL_CPU);
            end else begin
                grant_ext = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    sel_d   = grant_ext ? SEL_EXT : SEL_CPU;
                    we_d    = grant_ext ? ext_we    : cpu_we;
                    addr_d  = grant_ext ? ext_addr  : cpu_addr;
                    wdata_d = grant_ext ? ext_wdata : cpu_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = mem_rdata;
                last_d  = sel_q;
                state_d = RESP;
            end
            RESP: begin
                // Requests are deliberately not sampled here; the requester
                // gets one IDLE cycle to drop or replace its request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= SEL_CPU;
            last_q  <= SEL_EXT;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // mem_we comes only from registers, so it is glitch-free and falls the
    // moment reset forces the state back to IDLE.
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_ack   = (state_q == RESP) && (sel_q == SEL_CPU);
    assign ext_ack   = (state_q == RESP) && (sel_q == SEL_EXT);
    assign cpu_rdata = rdata_q;
    assign ext_rdata = rdata_q;
    assign cpu_stall = cpu_req && !cpu_ack;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter (round-robin and fixed-priority instances)

module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ext_req, ext_we;
    logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

    // index 0: ROUND_ROBIN = 1, index 1: ROUND_ROBIN = 0
    logic       cpu_ack [2];
    logic       ext_ack [2];
    logic       cpu_stall [2];
    logic       mem_we [2];
    logic       busy [2];
    logic [7:0] cpu_rdata [2];
    logic [7:0] ext_rdata [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack[0]), .ext_rdata(ext_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    dmem_arbiter #(.AW(8), .DW(8), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack[1]), .ext_rdata(ext_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    assign mem_rdata[0] = mem0[mem_addr[0]];
    assign mem_rdata[1] = mem1[mem_addr[1]];

    always @(posedge clk) if (mem_we[0]) mem0[mem_addr[0]] <= mem_wdata[0];
    always @(posedge clk) if (mem_we[1]) mem1[mem_addr[1]] <= mem_wdata[1];

    // Reset held 22 time units with cpu_req high; request is the store used next.
    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h3C; cpu_wdata = 8'h1C;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]} !== 5'b00001) begin
                    n_bad++;
                    $display("FAIL reset_ctrl dut%0d: got %b expected 00001", d,
                             {cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]});
                end
                n_vec++;
                if ({mem_addr[d], mem_wdata[d], cpu_rdata[d], ext_rdata[d]} !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_bus dut%0d: got %h expected 00000000", d,
                             {mem_addr[d], mem_wdata[d], cpu_rdata[d], ext_rdata[d]});
                end
            end
        end
        #2 reset = 1'b1;
    endtask

    // {cpu_ack, ext_ack, mem_we, busy, cpu_stall} per negedge after release.
    task automatic test_cpu_store();
        logic [4:0] exp_ctl [3];
        exp_ctl[0] = 5'b00111;
        exp_ctl[1] = 5'b10010;
        exp_ctl[2] = 5'b00000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]} !== exp_ctl[c]) begin
                    n_bad++;
                    $display("FAIL store_ctl dut%0d cyc%0d: got %b expected %b", d, c,
                             {cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]}, exp_ctl[c]);
                end
                if (c == 0) begin
                    n_vec++;
                    if ({mem_addr[d], mem_wdata[d]} !== 16'h3C1C) begin
                        n_bad++;
                        $display("FAIL store_bus dut%0d: got %h expected 3c1c", d, {mem_addr[d], mem_wdata[d]});
                    end
                end
            end
            if (c == 1) cpu_req = 1'b0;
        end
        n_vec++;
        if ({mem0[8'h3C], mem1[8'h3C]} !== 16'h1C1C) begin
            n_bad++;
            $display("FAIL store_mem: got %h expected 1c1c", {mem0[8'h3C], mem1[8'h3C]});
        end
    endtask

    // Load back; the address input changes mid-flight and must be ignored.
    task automatic test_cpu_load();
        logic [4:0] exp_ctl [3];
        exp_ctl[0] = 5'b00011;
        exp_ctl[1] = 5'b10010;
        exp_ctl[2] = 5'b00000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h3C; cpu_wdata = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]} !== exp_ctl[c]) begin
                    n_bad++;
                    $display("FAIL load_ctl dut%0d cyc%0d: got %b expected %b", d, c,
                             {cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]}, exp_ctl[c]);
                end
                if (c < 2) begin
                    n_vec++;
                    if (mem_addr[d] !== 8'h3C) begin
                        n_bad++;
                        $display("FAIL load_addr dut%0d cyc%0d: got %h expected 3c", d, c, mem_addr[d]);
                    end
                end
                if (c == 1) begin
                    n_vec++;
                    if (cpu_rdata[d] !== 8'h1C) begin
                        n_bad++;
                        $display("FAIL load_rdata dut%0d: got %h expected 1c", d, cpu_rdata[d]);
                    end
                end
            end
            if (c == 0) cpu_addr = 8'h00;
            if (c == 1) cpu_req = 1'b0;
        end
    endtask

    // Ext-only load; also leaves last served = EXT in both instances.
    task automatic test_ext_access();
        logic [4:0] exp_ctl [3];
        exp_ctl[0] = 5'b00010;
        exp_ctl[1] = 5'b01010;
        exp_ctl[2] = 5'b00000;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h3C; ext_wdata = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]} !== exp_ctl[c]) begin
                    n_bad++;
                    $display("FAIL ext_ctl dut%0d cyc%0d: got %b expected %b", d, c,
                             {cpu_ack[d], ext_ack[d], mem_we[d], busy[d], cpu_stall[d]}, exp_ctl[c]);
                end
                if (c == 1) begin
                    n_vec++;
                    if (ext_rdata[d] !== 8'h1C) begin
                        n_bad++;
                        $display("FAIL ext_rdata dut%0d: got %h expected 1c", d, ext_rdata[d]);
                    end
                end
            end
            if (c == 1) ext_req = 1'b0;
        end
    endtask

    // Both requesting: rr grants C,E,C,E; fixed priority grants C every 3 cycles.
    // cpu_req drops after 12 cycles, ext is then served by both.
    task automatic test_contention();
        logic exp_c, exp_e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50; cpu_wdata = 8'h00;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h51; ext_wdata = 8'hAA;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_c = (k <= 12) && (k % 3 == 2) && (d == 1 || k % 6 == 2);
                exp_e = (k == 14) || ((k <= 12) && (k % 3 == 2) && d == 0 && k % 6 == 5);
                n_vec++;
                if ({cpu_ack[d], ext_ack[d]} !== {exp_c, exp_e}) begin
                    n_bad++;
                    $display("FAIL contend_acks dut%0d cyc%0d: got %b expected %b", d, k,
                             {cpu_ack[d], ext_ack[d]}, {exp_c, exp_e});
                end
                if (exp_c) begin
                    n_vec++;
                    if (cpu_rdata[d] !== 8'hAF) begin
                        n_bad++;
                        $display("FAIL contend_rdata dut%0d cyc%0d: got %h expected af", d, k, cpu_rdata[d]);
                    end
                end
            end
            if (k == 12) cpu_req = 1'b0;
            if (k == 14) ext_req = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (busy[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL contend_idle dut%0d: got %b expected 0", d, busy[d]);
            end
        end
        n_vec++;
        if ({mem0[8'h51], mem1[8'h51]} !== 16'hAAAA) begin
            n_bad++;
            $display("FAIL contend_mem: got %h expected aaaa", {mem0[8'h51], mem1[8'h51]});
        end
    endtask

    // Addresses 0xFF and 0x00 pass straight through.
    task automatic test_addr_edges();
        logic       op_ext [3];
        logic       op_we [3];
        logic [7:0] op_addr [3];
        logic [7:0] op_wdata [3];
        logic [7:0] op_rdata [3];
        op_ext[0] = 1'b0; op_we[0] = 1'b1; op_addr[0] = 8'hFF; op_wdata[0] = 8'h77; op_rdata[0] = 8'h00;
        op_ext[1] = 1'b1; op_we[1] = 1'b0; op_addr[1] = 8'hFF; op_wdata[1] = 8'h12; op_rdata[1] = 8'h77;
        op_ext[2] = 1'b1; op_we[2] = 1'b1; op_addr[2] = 8'h00; op_wdata[2] = 8'h33; op_rdata[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (op_ext[i]) begin
                ext_req = 1'b1; ext_we = op_we[i]; ext_addr = op_addr[i]; ext_wdata = op_wdata[i];
            end else begin
                cpu_req = 1'b1; cpu_we = op_we[i]; cpu_addr = op_addr[i]; cpu_wdata = op_wdata[i];
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({mem_addr[d], mem_we[d], mem_wdata[d]} !== {op_addr[i], op_we[i], op_wdata[i]}) begin
                    n_bad++;
                    $display("FAIL edge_bus dut%0d op%0d: got %h expected %h", d, i,
                             {mem_addr[d], mem_we[d], mem_wdata[d]}, {op_addr[i], op_we[i], op_wdata[i]});
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({cpu_ack[d], ext_ack[d]} !== {!op_ext[i], op_ext[i]}) begin
                    n_bad++;
                    $display("FAIL edge_ack dut%0d op%0d: got %b expected %b", d, i,
                             {cpu_ack[d], ext_ack[d]}, {!op_ext[i], op_ext[i]});
                end
                if (!op_we[i]) begin
                    n_vec++;
                    if (ext_rdata[d] !== op_rdata[i]) begin
                        n_bad++;
                        $display("FAIL edge_rdata dut%0d op%0d: got %h expected %h", d, i, ext_rdata[d], op_rdata[i]);
                    end
                end
            end
            cpu_req = 1'b0;
            ext_req = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ({mem0[8'hFF], mem1[8'hFF], mem0[8'h00], mem1[8'h00]} !== 32'h77773333) begin
            n_bad++;
            $display("FAIL edge_mem: got %h expected 77773333",
                     {mem0[8'hFF], mem1[8'hFF], mem0[8'h00], mem1[8'h00]});
        end
    endtask

    // Reset mid-ACCESS of an ext store: write abandoned, no ack.
    task automatic test_reset_mid_access();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h51; ext_wdata = 8'h55;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({mem_we[d], busy[d]} !== 2'b11) begin
                n_bad++;
                $display("FAIL midrst_pre dut%0d: got %b expected 11", d, {mem_we[d], busy[d]});
            end
        end
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({mem_we[d], busy[d], ext_ack[d], cpu_ack[d]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL midrst_now dut%0d: got %b expected 0000", d,
                         {mem_we[d], busy[d], ext_ack[d], cpu_ack[d]});
            end
        end
        ext_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({mem_we[d], busy[d], ext_ack[d]} !== 3'b000) begin
                n_bad++;
                $display("FAIL midrst_post dut%0d: got %b expected 000", d, {mem_we[d], busy[d], ext_ack[d]});
            end
        end
        n_vec++;
        if ({mem0[8'h51], mem1[8'h51]} !== 16'hAAAA) begin
            n_bad++;
            $display("FAIL midrst_mem: got %h expected aaaa", {mem0[8'h51], mem1[8'h51]});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = ~i[7:0];
            mem1[i] = ~i[7:0];
        end
        test_reset();
        test_cpu_store();
        test_cpu_load();
        test_ext_access();
        test_contention();
        test_addr_edges();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
